sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, successor to the fixed-size FIFO used in the current verification environment. Generalised in data width and depth, with programmable almost-full/almost-empty thresholds, an occupancy count, and simultaneous read/write when full. Sits between a producer and a consumer in the same clock domain. Drives the same status set as the existing FIFO interface (full, empty, almost flags, wr_ack, overflow, underflow), so the existing bench structure carries over.

Parameters:
- DATA_WIDTH, 16: data bus width in bits, ≥1.
- DEPTH, 8: number of entries, ≥2, any integer (not restricted to power of two).
- AF_THRESH, DEPTH-1: almostfull asserts when count ≥ AF_THRESH; legal range 1..DEPTH-1.
- AE_THRESH, 1: almostempty asserts when count ≤ AE_THRESH and count > 0; legal range 1..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- full  out  1  count == DEPTH (combinational from count).
- empty  out  1  count == 0 (combinational from count).
- almostfull  out  1  count ≥ AF_THRESH.
- almostempty  out  1  0 < count ≤ AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert; sync release on the next clk edge): wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. Flags follow from count: empty=1, full=0, almostfull=0, almostempty=0. Memory contents are not cleared.
- Pointers: range 0..DEPTH-1. Increment wraps DEPTH-1 → 0 by explicit compare, not bit truncation.
- Write accept: wr_acc = wr_en && (!full || rd_en). On accept:
  - mem[wr_ptr] <= data_in; wr_ptr advances.
  - wr_ack=1 next cycle; otherwise wr_ack=0.
- Write reject (wr_en && !wr_acc): overflow=1 for one cycle; memory and pointers unchanged.
- Read accept: rd_acc = rd_en && !empty. On accept, data_out <= mem[rd_ptr] and rd_ptr advances. Latency is 1 cycle from rd_en to valid data_out. data_out holds its value when there is no read.
- Read reject (rd_en && empty): underflow=1 for one cycle. data_out holds.
- Count update: count += wr_acc − rd_acc. Count is never < 0 and never > DEPTH.
- Full with wr_en && rd_en: both accepted. Count stays DEPTH. wr_ack=1, overflow=0.
- Empty with wr_en && rd_en: only the write is accepted. underflow=1, wr_ack=1, count becomes 1. No write-to-read bypass.
- wr_ack, overflow and underflow are registered pulses, each asserted for exactly one cycle per event.
- Reset mid-operation: all state returns to reset values immediately, including pulse outputs. Accesses in the cycle rst is released are ignored.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out always shows mem[rd_ptr] when !empty; it is 0 when empty.
  - rd_en acts as a pop acknowledge. The first written word appears on data_out one cycle after the write, with no rd_en needed.
  - empty/full/count semantics are unchanged.
- Undefined: standard mode with registered read as above.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, data_out=0, all pulses 0.
- DEPTH=8: write 0x0001..0x0008 → wr_ack pulses 8 times, full=1, count=8, almostfull from count=7. 9th write → overflow=1 one cycle, count stays 8.
- Read 8 words from full → data_out 0x0001..0x0008 in order, 1-cycle latency, empty=1 after the last read. 9th read → underflow=1, data_out holds 0x0008.
- Full FIFO, wr_en=rd_en=1 with data_in=0xAAAA for 3 cycles → count stays 8, no overflow, data_out 0x0001..0x0003, pointers wrap.
- DEPTH=5, AF_THRESH=3, AE_THRESH=2: 12 writes interleaved with 12 reads → pointer wrap at 4→0 is correct, the flags track count exactly, and the data order is preserved.
- Assert rst with count=4 mid-burst → count=0, empty=1, and pulses clear in the same cycle. After release, a write of 0x1234 then a read → data_out=0x1234 (FWFT build: visible without rd_en).

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, and simultaneous
// read/write when full.
//
// Optional build macro: FIFO_FWFT_EN selects first-word fall-through.
//   Defined:   data_out shows mem[rd_ptr] combinationally (0 when empty);
//              rd_en acts as a pop acknowledge.
//   Undefined: registered read, 1-cycle latency, data_out holds between reads.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   wr_en, data_in    write request and data
//   rd_en, data_out   read request (pop in FWFT) and data
//   wr_ack            previous-cycle write accepted (1-cycle pulse)
//   overflow          previous-cycle write rejected (1-cycle pulse)
//   underflow         previous-cycle read rejected (1-cycle pulse)
//   full, empty       count == DEPTH / count == 0
//   almostfull        count >= AF_THRESH
//   almostempty       0 < count <= AE_THRESH
//   count             current occupancy, 0..DEPTH
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almostfull,
  output logic                         almostempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  rst_q;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status flags and accept decisions, all derived from count.
  always_comb begin
    full        = (count == CW'(DEPTH));
    empty       = (count == '0);
    almostfull  = (count >= CW'(AF_THRESH));
    almostempty = !empty && (count <= CW'(AE_THRESH));
    // rst_q masks requests on the first edge after reset release.
    wr_req      = wr_en && !rst_q;
    rd_req      = rd_en && !rst_q;
    wr_acc      = wr_req && (!full || rd_req);
    rd_acc      = rd_req && !empty;
  end

  // Release flag: set by reset, cleared by the first clock edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 1'b1;
    else     rst_q <= 1'b0;
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_req && !wr_acc;
      underflow <= rd_req && empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head of queue visible as soon as it is written.
  always_comb begin
    data_out = empty ? '0 : mem[rd_ptr];
  end
`else
  // Registered read; holds when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a DEPTH=8 default instance and a DEPTH=5
// instance with AF=3/AE=2, each checked every cycle against a queue model.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        w8 = 0, r8 = 0;
  logic [15:0] d8 = '0, do8;
  logic        ack8, ov8, un8, f8, e8, af8, ae8;
  logic [3:0]  c8;

  logic        w5 = 0, r5 = 0;
  logic [15:0] d5 = '0, do5;
  logic        ack5, ov5, un5, f5, e5, af5, ae5;
  logic [2:0]  c5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param u8 (
    .clk(clk), .rst(rst), .wr_en(w8), .rd_en(r8), .data_in(d8), .data_out(do8),
    .wr_ack(ack8), .overflow(ov8), .underflow(un8), .full(f8), .empty(e8),
    .almostfull(af8), .almostempty(ae8), .count(c8)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) u5 (
    .clk(clk), .rst(rst), .wr_en(w5), .rd_en(r5), .data_in(d5), .data_out(do5),
    .wr_ack(ack5), .overflow(ov5), .underflow(un5), .full(f5), .empty(e5),
    .almostfull(af5), .almostempty(ae5), .count(c5)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue models: accept rules, pulses and read data from the FIFO rules.
  logic [15:0] q8[$];
  logic [15:0] q5[$];
  logic [15:0] m8_dout = '0, m5_dout = '0;
  bit m8_ack, m8_ovf, m8_unf, m8_rel;
  bit m5_ack, m5_ovf, m5_unf, m5_rel;
  bit wa8, ra8, wa5, ra5;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q8.delete(); m8_dout = '0; m8_ack = 0; m8_ovf = 0; m8_unf = 0; m8_rel = 1;
    end else if (m8_rel) begin
      m8_rel = 0; m8_ack = 0; m8_ovf = 0; m8_unf = 0;
    end else begin
      wa8 = w8 && (q8.size() < 8 || r8);
      ra8 = r8 && (q8.size() > 0);
      m8_ack = wa8;
      m8_ovf = w8 && !wa8;
      m8_unf = r8 && (q8.size() == 0);
      if (ra8) m8_dout = q8.pop_front();
      if (wa8) q8.push_back(d8);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q5.delete(); m5_dout = '0; m5_ack = 0; m5_ovf = 0; m5_unf = 0; m5_rel = 1;
    end else if (m5_rel) begin
      m5_rel = 0; m5_ack = 0; m5_ovf = 0; m5_unf = 0;
    end else begin
      wa5 = w5 && (q5.size() < 5 || r5);
      ra5 = r5 && (q5.size() > 0);
      m5_ack = wa5;
      m5_ovf = w5 && !wa5;
      m5_unf = r5 && (q5.size() == 0);
      if (ra5) m5_dout = q5.pop_front();
      if (wa5) q5.push_back(d5);
    end
  end

  // Per-cycle comparison against the models.
  always @(negedge clk) begin
    int n8, n5;
    n8 = q8.size();
    n5 = q5.size();
    chk("cnt8",  int'(c8),   n8);
    chk("full8", int'(f8),   int'(n8 == 8));
    chk("emp8",  int'(e8),   int'(n8 == 0));
    chk("af8",   int'(af8),  int'(n8 >= 7));
    chk("ae8",   int'(ae8),  int'(n8 > 0 && n8 <= 1));
    chk("ack8",  int'(ack8), int'(m8_ack));
    chk("ovf8",  int'(ov8),  int'(m8_ovf));
    chk("unf8",  int'(un8),  int'(m8_unf));
    chk("cnt5",  int'(c5),   n5);
    chk("full5", int'(f5),   int'(n5 == 5));
    chk("emp5",  int'(e5),   int'(n5 == 0));
    chk("af5",   int'(af5),  int'(n5 >= 3));
    chk("ae5",   int'(ae5),  int'(n5 > 0 && n5 <= 2));
    chk("ack5",  int'(ack5), int'(m5_ack));
    chk("ovf5",  int'(ov5),  int'(m5_ovf));
    chk("unf5",  int'(un5),  int'(m5_unf));
`ifdef FIFO_FWFT_EN
    chk("dout8", int'(do8), (n8 > 0) ? int'(q8[0]) : 0);
    chk("dout5", int'(do5), (n5 > 0) ? int'(q5[0]) : 0);
`else
    chk("dout8", int'(do8), int'(m8_dout));
    chk("dout5", int'(do5), int'(m5_dout));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    tick();
    chk("lit_rst_cnt",   int'(c8),  0);
    chk("lit_rst_empty", int'(e8),  1);
    chk("lit_rst_full",  int'(f8),  0);
    chk("lit_rst_dout",  int'(do8), 0);
    chk("lit_rst_ack",   int'(ack8), 0);

    // Fill DEPTH=8 with 1..8.
    w8 = 1;
    for (int i = 1; i <= 8; i++) begin
      d8 = 16'(i);
      tick();
      if (i == 6) chk("lit_af_at6", int'(af8), 0);
      if (i == 7) chk("lit_af_at7", int'(af8), 1);
    end
    chk("lit_full_cnt", int'(c8), 8);
    chk("lit_full",     int'(f8), 1);
    d8 = 16'h0009;
    tick();
    chk("lit_ovf9",  int'(ov8), 1);
    chk("lit_cnt9",  int'(c8),  8);
    w8 = 0;
    tick();
    chk("lit_ovf_drop", int'(ov8), 0);

    // Simultaneous read/write while full.
    w8 = 1; r8 = 1; d8 = 16'hAAAA;
    repeat (3) tick();
    chk("lit_simul_cnt", int'(c8), 8);
`ifdef FIFO_FWFT_EN
    chk("lit_simul_dout", int'(do8), 16'h0004);
`else
    chk("lit_simul_dout", int'(do8), 16'h0003);
`endif
    w8 = 0;
    repeat (8) tick();
    chk("lit_drained", int'(e8), 1);
    tick();
    chk("lit_unf", int'(un8), 1);
`ifdef FIFO_FWFT_EN
    chk("lit_unf_dout", int'(do8), 0);
`else
    chk("lit_unf_dout", int'(do8), 16'hAAAA);
`endif
    r8 = 0;

    // Empty with both requests: write only.
    w8 = 1; r8 = 1; d8 = 16'h0055;
    tick();
    chk("lit_er_unf", int'(un8),  1);
    chk("lit_er_ack", int'(ack8), 1);
    chk("lit_er_cnt", int'(c8),   1);
    w8 = 0;
    tick();
    r8 = 0;
    tick();

    // DEPTH=5: 12 writes interleaved with reads, then drain past empty.
    for (int i = 0; i < 12; i++) begin
      w5 = 1; d5 = 16'(16'h0100 + i); r5 = (i % 2 == 1);
      tick();
    end
    w5 = 0; r5 = 1;
    repeat (8) tick();
    r5 = 0;
    tick();

    // Reset mid-burst with four words held.
    w8 = 1;
    for (int i = 0; i < 4; i++) begin
      d8 = 16'(16'h0011 + i);
      tick();
    end
    chk("lit_mid_cnt", int'(c8), 4);
    d8 = 16'h0099;
    rst = 1;
    #1;
    chk("lit_mrst_cnt",   int'(c8),   0);
    chk("lit_mrst_empty", int'(e8),   1);
    chk("lit_mrst_ack",   int'(ack8), 0);
    @(posedge clk);
    #2 rst = 0;
    d8 = 16'hDEAD;
    tick();
    chk("lit_rel_cnt", int'(c8),   0);
    chk("lit_rel_ack", int'(ack8), 0);
    d8 = 16'h1234;
    tick();
    w8 = 0;
`ifdef FIFO_FWFT_EN
    chk("lit_fwft_1234", int'(do8), 16'h1234);
`endif
    r8 = 1;
    tick();
    r8 = 0;
`ifndef FIFO_FWFT_EN
    chk("lit_rd_1234", int'(do8), 16'h1234);
`endif
    chk("lit_end_cnt", int'(c8), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
